// File: rtl/pe_arbiter.sv
// pe_arbiter: grants one shared resource to one of NREQ requesters.
// The grant is held until the owner signals done, drops its request, or
// reaches the hold limit. After that comes one turnaround cycle and then a
// fresh decision. Fixed-priority mode (index 7 highest) and rotating mode
// are both supported.
module pe_arbiter #(
  parameter int NREQ     = 8,
  parameter int IDXW     = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_n,
  input  logic            rr_mode,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_vld,
  output logic            busy,
  output logic            timeout
);

  // A MAX_HOLD of 0 means "no limit"; keep the counter at least 1 bit wide.
  localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HCW-1:0] HOLD_SAT  = HCW'((MAX_HOLD > 0) ? MAX_HOLD : 0);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t          state, state_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [IDXW-1:0] idx_nxt;
  logic            vld_nxt;
  logic            timeout_nxt;
  logic [HCW-1:0]  hold_cnt, hold_nxt;
  logic [IDXW-1:0] rr_ptr, rr_nxt;
  logic [IDXW-1:0] owner, owner_nxt;

  logic [IDXW-1:0] fixed_win, rr_win, cand, win;
  logic            rr_found;
  logic            owner_exit, limit_exit;

  // Winner selection: highest set bit, or first set bit searching downward from rr_ptr.
  always_comb begin
    fixed_win = '0;
    rr_win    = '0;
    rr_found  = 1'b0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i]) fixed_win = IDXW'(i);
    end
    for (int i = 0; i < NREQ; i++) begin
      cand = rr_ptr - IDXW'(i);
      if (!rr_found && req[cand]) begin
        rr_win   = cand;
        rr_found = 1'b1;
      end
    end
    win = rr_mode ? rr_win : fixed_win;
  end

  // Next-state and next-output logic for the IDLE -> GRANT -> RELEASE cycle.
  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    idx_nxt     = gnt_idx;
    vld_nxt     = gnt_vld;
    timeout_nxt = 1'b0;
    hold_nxt    = hold_cnt;
    rr_nxt      = rr_ptr;
    owner_nxt   = owner;
    owner_exit  = done || !req[owner];
    limit_exit  = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        idx_nxt = '0;
        vld_nxt = 1'b0;
        if (!en_n && (|req)) begin
          state_nxt = GRANT;
          gnt_nxt   = NREQ'(1) << win;
          idx_nxt   = win;
          owner_nxt = win;
          vld_nxt   = 1'b1;
          hold_nxt  = '0;
        end
      end
      GRANT: begin
        if (hold_cnt != HOLD_SAT) hold_nxt = hold_cnt + HCW'(1);
        if (owner_exit || limit_exit) begin
          state_nxt   = RELEASE;
          gnt_nxt     = '0;
          idx_nxt     = '0;
          vld_nxt     = 1'b0;
          timeout_nxt = !owner_exit;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
        rr_nxt    = owner - IDXW'(1);
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        idx_nxt   = '0;
        vld_nxt   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops any grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_idx  <= '0;
      gnt_vld  <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      rr_ptr   <= IDXW'(NREQ - 1);
      owner    <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      gnt_idx  <= idx_nxt;
      gnt_vld  <= vld_nxt;
      timeout  <= timeout_nxt;
      hold_cnt <= hold_nxt;
      rr_ptr   <= rr_nxt;
      owner    <= owner_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_pe_arbiter.sv
// tb_pe_arbiter: directed tests of pe_arbiter against a behavioural model
// that tracks owner, cycles held and the rotating pointer as plain integers.
module tb_pe_arbiter;

  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_n = 1'b1;
  logic       rr_mode = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // Model state: phase 0 = idle, 1 = granted, 2 = turnaround.
  int m_phase = 0;
  int m_owner = 0;
  int m_held = 0;
  int m_ptr = 7;
  bit m_timeout = 1'b0;

  pe_arbiter #(.NREQ(8), .IDXW(3), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .en_n(en_n), .rr_mode(rr_mode), .req(req),
    .done(done), .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [7:0] r, input bit rr, input int p);
    int res;
    res = -1;
    if (!rr) begin
      for (int i = 0; i < 8; i++) if (r[i]) res = i;
    end else begin
      for (int k = 7; k >= 0; k--) if (r[(p - k + 8) % 8]) res = (p - k + 8) % 8;
    end
    return res;
  endfunction

  // Behavioural model advanced on each rising edge with the inputs seen there.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_owner = 0; m_held = 0; m_ptr = 7; m_timeout = 1'b0;
    end else begin
      m_timeout = 1'b0;
      if (m_phase == 0) begin
        if (!en_n && req != 8'h00) begin
          m_owner = pick(req, rr_mode, m_ptr);
          m_held = 1;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (done || !req[m_owner]) begin
          m_phase = 2;
        end else if (MAX_HOLD != 0 && m_held == MAX_HOLD) begin
          m_phase = 2;
          m_timeout = 1'b1;
        end else begin
          m_held++;
        end
      end else begin
        m_ptr = (m_owner + 7) % 8;
        m_phase = 0;
      end
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every falling edge: the DUT outputs must match the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check_output("model_vld", int'(gnt_vld), int'(m_phase == 1));
      check_output("model_gnt", int'(gnt), (m_phase == 1) ? (1 << m_owner) : 0);
      check_output("model_idx", int'(gnt_idx), (m_phase == 1) ? m_owner : 0);
      check_output("model_busy", int'(busy), int'(m_phase != 0));
      check_output("model_timeout", int'(timeout), int'(m_timeout));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] r, input logic en, input logic rr, input logic d);
    req = r; en_n = en; rr_mode = rr; done = d;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    while (!gnt_vld && n < 20) begin
      step(1);
      n++;
    end
    if (!gnt_vld) begin
      checks++;
      failures++;
      $display("[TB] FAIL wait_grant actual=no_grant expected=grant within 20 cycles");
    end
  endtask

  int rr_seq[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
  int held;

  initial begin
    apply_stimulus(8'h00, 1'b1, 1'b0, 1'b0);
    step(2);
    check_output("reset_gnt", int'(gnt), 0);
    check_output("reset_vld", int'(gnt_vld), 0);
    check_output("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    step(1);

    // Test 1: fixed priority picks index 7 with latency 1.
    apply_stimulus(8'b1010_0100, 1'b0, 1'b0, 1'b0);
    step(1);
    check_output("t1_gnt", int'(gnt), 8'h80);
    check_output("t1_idx", int'(gnt_idx), 7);
    check_output("t1_vld", int'(gnt_vld), 1);
    done = 1'b1;
    step(1);
    check_output("t1_release_vld", int'(gnt_vld), 0);
    check_output("t1_release_busy", int'(busy), 1);
    apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0);
    step(1);
    check_output("t1_idle_busy", int'(busy), 0);

    // Test 2: round robin rotates 7 down to 0 and wraps.
    apply_reset();
    apply_stimulus(8'hFF, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 9; k++) begin
      wait_grant();
      check_output("t2_rr_idx", int'(gnt_idx), rr_seq[k]);
      step(1);
      done = 1'b1;
      step(1);
      done = 1'b0;
    end
    req = 8'h00;
    step(3);

    // Test 3: forced release after 16 cycles, and done on cycle 16 suppresses timeout.
    apply_stimulus(8'h08, 1'b0, 1'b0, 1'b0);
    wait_grant();
    held = 1;
    for (int n = 0; n < 40 && gnt_vld; n++) begin
      step(1);
      if (gnt_vld) held++;
    end
    check_output("t3_hold_cycles", held, 16);
    check_output("t3_timeout_pulse", int'(timeout), 1);
    req = 8'h00;
    step(1);
    check_output("t3_timeout_clear", int'(timeout), 0);
    step(1);
    req = 8'h08;
    wait_grant();
    step(15);
    check_output("t3_vld_cycle16", int'(gnt_vld), 1);
    done = 1'b1;
    step(1);
    check_output("t3_done_vld", int'(gnt_vld), 0);
    check_output("t3_done_no_timeout", int'(timeout), 0);
    apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0);
    step(2);

    // Test 4: disabled arbitration never grants; disabling mid-grant does not abort.
    apply_stimulus(8'h01, 1'b1, 1'b0, 1'b0);
    step(3);
    check_output("t4_no_grant", int'(gnt_vld), 0);
    en_n = 1'b0;
    wait_grant();
    check_output("t4_idx", int'(gnt_idx), 0);
    en_n = 1'b1;
    step(3);
    check_output("t4_hold_vld", int'(gnt_vld), 1);
    done = 1'b1;
    step(1);
    check_output("t4_done_vld", int'(gnt_vld), 0);
    apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0);
    step(2);

    // Test 5: owner dropping its request releases; pointer then starts at 4.
    apply_reset();
    apply_stimulus(8'h20, 1'b0, 1'b1, 1'b0);
    wait_grant();
    check_output("t5_idx", int'(gnt_idx), 5);
    step(2);
    req = 8'h00;
    step(1);
    check_output("t5_drop_vld", int'(gnt_vld), 0);
    req = 8'hFF;
    wait_grant();
    check_output("t5_rr_next", int'(gnt_idx), 4);

    // Test 6: asynchronous reset mid-grant, then RR restarts at 7.
    step(1);
    rst_n = 1'b0;
    #1;
    check_output("t6_async_gnt", int'(gnt), 0);
    check_output("t6_async_vld", int'(gnt_vld), 0);
    check_output("t6_async_busy", int'(busy), 0);
    step(1);
    rst_n = 1'b1;
    wait_grant();
    check_output("t6_after_reset_idx", int'(gnt_idx), 7);
    done = 1'b1;
    step(1);
    apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0);
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
